// File: rtl/instr_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package instr_fetch_pkg;

    localparam int unsigned WORD_SIZE = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INCR   = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_SIZE-1:0] instr;
        logic [WORD_SIZE-1:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: imem request/response, decode handshake and redirect.
interface instr_fetch_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        fetch_fault;

    modport master (
        output imem_req_valid, imem_addr, instr_valid, instruction, instr_pc, fetch_fault,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               redirect_valid, redirect_target
    );

    modport slave (
        input  imem_req_valid, imem_addr, instr_valid, instruction, instr_pc, fetch_fault,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               redirect_valid, redirect_target
    );

endinterface

// File: rtl/instr_fetch_buffer.sv
// Synchronous FIFO of {instruction, pc} entries between imem responses and decode.
module fetch_buffer
    import instr_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    fetch_entry_t  mem [DEPTH];
    fetch_entry_t  hold;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_pop;

    assign empty  = (count == '0);
    assign full   = (32'(count) == DEPTH);
    assign do_pop = pop && !empty;
    // hold tracks whatever was last presented so the head is stable while empty
    assign head   = empty ? hold : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            hold   <= '{instr: NOP_INSTR, pc: '0};
        end else begin
            hold <= head;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)   wr_ptr <= wr_ptr + AW'(1);
                if (do_pop) rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(do_pop);
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, request credit, in-flight PC queue and redirect/flush control.
// Optional misaligned-redirect fault via FETCH_MISALIGN_CHK_EN.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH    = 2,
    parameter int unsigned MAX_INFLIGHT = 2
) (
    input logic           clk,
    input logic           reset_n,
    instr_fetch_if.master bus
);

    localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t  state;
    logic [31:0]   pc;
    logic [31:0]   target;
    logic [IW-1:0] inflight;
    logic [IW-1:0] inflight_next;
    logic [IW-1:0] drop;
    logic [31:0]   pc_q [MAX_INFLIGHT];
    logic [PW-1:0] pq_head;
    logic [PW-1:0] pq_tail;
    logic [CW-1:0] count;
    logic          buf_empty;
    logic          buf_full;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;
    logic          req_valid;
    logic          req_fire;
    logic          rsp_drop;
    logic          rsp_keep;
    logic          pop;
    logic          fault;

    function automatic logic [PW-1:0] pq_next(input logic [PW-1:0] p);
        return (32'(p) == MAX_INFLIGHT - 1) ? '0 : p + PW'(1);
    endfunction

    // Credit counts dropped in-flight words too, so every accepted request owns a slot.
    always_comb begin
        req_valid = (state == RUN) && !bus.redirect_valid && !buf_full
                    && (32'(inflight) < MAX_INFLIGHT)
                    && (32'(inflight) + 32'(count) < BUF_DEPTH);
        req_fire      = req_valid && bus.imem_req_ready;
        rsp_drop      = bus.imem_rsp_valid && (bus.redirect_valid || drop != '0);
        rsp_keep      = bus.imem_rsp_valid && !rsp_drop;
        pop           = !buf_empty && bus.instr_ready;
        inflight_next = inflight + IW'(req_fire) - IW'(bus.imem_rsp_valid);
        push_entry    = '{instr: bus.imem_rsp_data, pc: pc_q[pq_head]};
    end

`ifdef FETCH_MISALIGN_CHK_EN
    assign target = bus.redirect_target;
`else
    assign target = align_word(bus.redirect_target);
    assign fault  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
            pq_head  <= '0;
            pq_tail  <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
            fault    <= 1'b0;
`endif
        end else begin
            inflight <= inflight_next;
            if (bus.redirect_valid) begin
                pc      <= target;
                drop    <= inflight_next;
                pq_head <= '0;
                pq_tail <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
                if (target[1:0] != 2'b00) begin
                    state <= FAULT;
                    fault <= 1'b1;
                end else begin
                    state <= RUN;
                    fault <= 1'b0;
                end
`else
                state   <= RUN;
`endif
            end else begin
                if (req_fire) begin
                    pc      <= pc + PC_INCR;
                    pq_tail <= pq_next(pq_tail);
                end
                if (rsp_drop) drop    <= drop - IW'(1);
                if (rsp_keep) pq_head <= pq_next(pq_head);
                if (state == IDLE) state <= RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            pc_q[pq_tail] <= pc;
        end
    end

    fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (rsp_keep),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (bus.redirect_valid),
        .head      (head),
        .count     (count),
        .empty     (buf_empty),
        .full      (buf_full)
    );

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_addr      = align_word(pc);
    assign bus.instr_valid    = !buf_empty;
    assign bus.instruction    = head.instr;
    assign bus.instr_pc       = head.pc;
    assign bus.fetch_fault    = fault;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios then randomized traffic
// against a program-order reference model with epoch-tagged imem responses.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned MAXI   = 2;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } ent_t;

    logic clk;
    logic reset_n;
    instr_fetch_if bus();

    instr_fetch #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH), .MAX_INFLIGHT(MAXI)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          tests = 0;
    int          fails = 0;
    int          rsp_mode, rdy_mode, dec_mode;
    int          epoch = 0;
    bit          running = 1'b0;
    bit          faulted = 1'b0;
    logic [31:0] exp_req_pc, exp_dec_pc;
    logic [31:0] pend_addr[$];
    int          pend_epoch[$];
    ent_t        exp_buf[$];
    logic [31:0] issued[$];
    logic [31:0] popped_pcs[$];
    logic [31:0] saved_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    function automatic bit pick(input int m);
        return (m == 1) || (m == 2 && $urandom_range(0, 3) != 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: got %h, want %h", tag, obs, want);
        end
    endtask

    task automatic model_clear();
        pend_addr.delete();
        pend_epoch.delete();
        exp_buf.delete();
        epoch++;
        running    = 1'b0;
        faulted    = 1'b0;
        exp_req_pc = RST_PC;
        exp_dec_pc = RST_PC;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req_valid"},   bus.imem_req_valid, 32'h0);
        chk({tag, "_instr_valid"}, bus.instr_valid,    32'h0);
        chk({tag, "_imem_addr"},   bus.imem_addr,      RST_PC);
        chk({tag, "_instruction"}, bus.instruction,    32'h0000_0013);
        chk({tag, "_instr_pc"},    bus.instr_pc,       32'h0);
        chk({tag, "_fetch_fault"}, bus.fetch_fault,    32'h0);
    endtask

    task automatic idle_inputs();
        bus.imem_req_ready  = 1'b0;
        bus.imem_rsp_valid  = 1'b0;
        bus.imem_rsp_data   = '0;
        bus.instr_ready     = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
    endtask

    // Entered at a negedge: drive, sample 1ns later, advance the model, return at the next negedge.
    task automatic step(input bit redir, input logic [31:0] tgt);
        bit          rsp, stale, exp_req, fire, popped;
        logic [31:0] ra;
        rsp = (pend_addr.size() != 0) && pick(rsp_mode);
        ra  = rsp ? pend_addr[0] : 32'h0;
        bus.imem_rsp_valid  = rsp;
        bus.imem_rsp_data   = rsp ? mem_word(ra) : $urandom;
        bus.imem_req_ready  = pick(rdy_mode);
        bus.instr_ready     = pick(dec_mode);
        bus.redirect_valid  = redir;
        bus.redirect_target = redir ? tgt : $urandom;
        #1;
        exp_req = running && !faulted && !redir && (pend_addr.size() < MAXI)
                  && (pend_addr.size() + exp_buf.size() < DEPTH);
        chk("imem_req_valid", bus.imem_req_valid, exp_req);
        chk("instr_valid", bus.instr_valid, exp_buf.size() != 0);
        chk("fetch_fault", bus.fetch_fault, faulted);
        if (bus.imem_req_valid) chk("imem_addr", bus.imem_addr, exp_req_pc);
        if (exp_buf.size() != 0) begin
            chk("head_pc", bus.instr_pc, exp_buf[0].pc);
            chk("head_instruction", bus.instruction, exp_buf[0].word);
        end
        fire   = bus.imem_req_valid && bus.imem_req_ready;
        popped = bus.instr_valid && bus.instr_ready;
        if (popped) begin
            chk("decode_pc_order", bus.instr_pc, exp_dec_pc);
            chk("decode_word", bus.instruction, mem_word(exp_dec_pc));
            popped_pcs.push_back(bus.instr_pc);
            exp_dec_pc += 32'd4;
            if (exp_buf.size() != 0) void'(exp_buf.pop_front());
        end
        if (rsp) begin
            stale = redir || (pend_epoch[0] != epoch);
            void'(pend_addr.pop_front());
            void'(pend_epoch.pop_front());
            if (!stale) exp_buf.push_back(ent_t'{word: mem_word(ra), pc: ra});
        end
        if (fire) begin
            pend_addr.push_back(bus.imem_addr);
            pend_epoch.push_back(epoch);
            issued.push_back(bus.imem_addr);
            exp_req_pc += 32'd4;
        end
        if (redir) begin
            epoch++;
            exp_buf.delete();
`ifdef FETCH_MISALIGN_CHK_EN
            faulted    = (tgt[1:0] != 2'b00);
            exp_req_pc = tgt;
`else
            exp_req_pc = tgt & ~32'h3;
`endif
            exp_dec_pc = exp_req_pc;
        end
        running = 1'b1;
        @(negedge clk);
    endtask

    task automatic rand_step();
        bit          redir;
        logic [31:0] tgt;
        redir = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0;
        else                           tgt = 32'($urandom_range(0, 1023)) << 2;
        if ($urandom_range(0, 7) == 0) tgt = tgt | 32'($urandom_range(1, 3));
        step(redir, tgt);
    endtask

    task automatic do_reset(input string tag);
        #3;
        reset_n = 1'b0;
        idle_inputs();
        #1;
        check_reset(tag);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_clear();
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Streaming with imem/decode always ready: wraps through 0
        rsp_mode = 1; rdy_mode = 1; dec_mode = 1;
        issued.delete(); popped_pcs.delete();
        repeat (12) step(1'b0, 32'h0);
        chk("wrap_addr0", issued[0], 32'hFFFF_FFF8);
        chk("wrap_addr1", issued[1], 32'hFFFF_FFFC);
        chk("wrap_addr2", issued[2], 32'h0000_0000);
        chk("wrap_addr3", issued[3], 32'h0000_0004);
        chk("stream_pc0", popped_pcs[0], 32'hFFFF_FFF8);
        chk("stream_pc2", popped_pcs[2], 32'h0000_0000);

        // Decode stalled: buffer fills, requests stop
        dec_mode = 0;
        repeat (10) step(1'b0, 32'h0);
        chk("stall_req_valid", bus.imem_req_valid, 32'h0);
        chk("stall_instr_valid", bus.instr_valid, 32'h1);
        saved_pc = exp_dec_pc;
        dec_mode = 1;
        popped_pcs.delete();
        repeat (6) step(1'b0, 32'h0);
        chk("resume_pc0", popped_pcs[0], saved_pc);
        chk("resume_pc1", popped_pcs[1], saved_pc + 32'd4);
        chk("resume_pc2", popped_pcs[2], saved_pc + 32'd8);

        // Redirect with two requests outstanding
        rsp_mode = 0;
        repeat (4) step(1'b0, 32'h0);
        step(1'b1, 32'h100);
        rsp_mode = 1;
        popped_pcs.delete();
        repeat (8) step(1'b0, 32'h0);
        chk("redirect_first_pc", popped_pcs[0], 32'h100);
        chk("redirect_second_pc", popped_pcs[1], 32'h104);

        // Redirect coinciding with a response and a pop
        rsp_mode = 0; dec_mode = 1;
        repeat (4) step(1'b0, 32'h0);
        rsp_mode = 1; dec_mode = 0;
        step(1'b0, 32'h0);
        dec_mode = 1;
        issued.delete(); popped_pcs.delete();
        step(1'b1, 32'h300);
        chk("redir_pop_completed", popped_pcs.size(), 32'd1);
        chk("redir_cycle_no_req", issued.size(), 32'd0);
        repeat (6) step(1'b0, 32'h0);
        chk("redir_next_addr", issued[0], 32'h300);

        // Misaligned redirect target
        repeat (3) step(1'b0, 32'h0);
        issued.delete();
        step(1'b1, 32'h102);
        repeat (6) step(1'b0, 32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("fault_flag", bus.fetch_fault, 32'h1);
        chk("fault_no_req", issued.size(), 32'd0);
        issued.delete();
        step(1'b1, 32'h200);
        repeat (5) step(1'b0, 32'h0);
        chk("fault_cleared", bus.fetch_fault, 32'h0);
        chk("fault_resume_addr", issued[0], 32'h200);
`else
        chk("misalign_addr", issued[0], 32'h100);
        chk("misalign_no_fault", bus.fetch_fault, 32'h0);
`endif

        // Randomized traffic, async reset mid-stream, more traffic
        rsp_mode = 2; rdy_mode = 2; dec_mode = 2;
        repeat (1500) rand_step();
        do_reset("midrst");
        issued.delete();
        repeat (400) rand_step();
        chk("post_reset_first_addr", issued[0], RST_PC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the instruction-type decoder.
- Owns the program counter and issues word-aligned requests to instruction memory.
- Buffers returned instruction words with their PC and presents them to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing buffered and in-flight instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BUF_DEPTH, 2, instruction buffer entries; must be a power of 2 and at least 2.
- MAX_INFLIGHT, 2, maximum outstanding imem requests without a response.

Ports:
- clk  input  1  system clock; all state is rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- imem_req_valid  output  1  request valid to instruction memory.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_addr  output  32  request byte address; bits [1:0] are always 0.
- imem_rsp_valid  input  1  response word valid; responses return in request order.
- imem_rsp_data  input  32  response instruction word.
- instr_valid  output  1  buffer head valid to decode.
- instr_ready  input  1  decode consumes the head this cycle.
- instruction  output  32  head instruction; feeds the decoder's instruction input.
- instr_pc  output  32  PC of the head instruction.
- redirect_valid  input  1  branch/jump taken.
- redirect_target  input  32  new PC.
- fetch_fault  output  1  misaligned-target flag; driven only with the optional feature, otherwise tied 0.

Behaviour:
- Reset (asynchronous, reset_n=0) values:
  - pc=RESET_PC; buffer empty; inflight=0; drop=0; state=IDLE.
  - imem_req_valid=0, instr_valid=0, instruction=32'h0000_0013 (NOP), instr_pc=0, fetch_fault=0.
- States:
  - IDLE: lasts exactly one cycle after reset release, then goes to RUN.
  - RUN: normal fetching.
  - FAULT: entered only with the optional feature.
- Request issue (RUN only):
  - imem_req_valid=1 when inflight<MAX_INFLIGHT, inflight+count<BUF_DEPTH, and redirect_valid=0.
  - imem_addr=pc.
  - On imem_req_valid & imem_req_ready: pc<=pc+4, with 32-bit wrap (32'hFFFF_FFFC+4=0), and inflight increments.
- Credit rule: the buffer can never overflow; every accepted request has a reserved slot.
- Response handling:
  - On imem_rsp_valid with drop>0: discard the word; drop and inflight each decrement.
  - Otherwise: push {imem_rsp_data, pc_of_request} into the buffer and decrement inflight.
  - Request PCs are held in a MAX_INFLIGHT-deep PC queue.
- Decode handshake:
  - instr_valid = buffer not empty.
  - instruction and instr_pc are driven combinationally from the buffer head.
  - Pop on instr_valid & instr_ready.
  - Push and pop in the same cycle are legal; count is unchanged.
  - A response arriving into an empty buffer becomes visible the next cycle; latency from rsp to instr_valid is 1 cycle.
- Redirect (redirect_valid=1, any state):
  - pc<=redirect_target; buffer flushed; instr_valid=0 the next cycle.
  - drop<=inflight (count after this cycle's request and response updates); PC queue cleared.
  - No request is issued in the redirect cycle.
  - A response arriving in the redirect cycle is discarded.
  - A pop in the redirect cycle still completes; decode owns that instruction.
  - Back-to-back redirects: the last one wins; drop accumulates correctly.
- Misaligned target without the feature: bits [1:0] of redirect_target are forced to 0.
- instruction holds its last value while the buffer is empty. instr_pc likewise holds; both are don't-care to decode while instr_valid=0.
- Reset mid-operation: everything returns immediately to reset values. Responses for pre-reset requests still return after reset_n rises and are not tracked by inflight/drop, so imem must be reset together with the fetch stage.

Optional Feature:
- FETCH_MISALIGN_CHK_EN defined:
  - A redirect with target[1:0]!=0 flushes as normal and loads pc with the unmodified target.
  - State moves to FAULT: no requests are issued and fetch_fault=1.
  - FAULT is left only on an aligned redirect (state to RUN, fetch_fault=0) or on reset.
- FETCH_MISALIGN_CHK_EN undefined:
  - Target bits [1:0] are cleared.
  - FAULT state is never entered.
  - fetch_fault is tied 0.

Decomposition:
- Add to constants.svh: WORD_SIZE, NOP_INSTR=32'h0000_0013, PC_INCR=4, and fetch state encodings IDLE/RUN/FAULT.
- Sub-module fetch_buffer: parameterised synchronous FIFO of {instruction, pc}, with push, pop, flush, count, empty and full.
- instr_fetch holds the PC, the PC queue, the inflight/drop counters and the state machine.

Test Plan:
- Reset release, imem always ready, 1-cycle response latency, decode always ready: imem_addr sequence 0,4,8,C; instr_pc follows 1 cycle after each response; instructions match memory words.
- instr_ready=0 for 10 cycles: exactly BUF_DEPTH instructions are buffered; imem_req_valid drops to 0; no overflow; resuming instr_ready delivers instr_pc 0,4 then 8 in order.
- Redirect to 32'h100 with 2 requests in flight: both responses are dropped; next instr_pc=32'h100; no stale PC reaches decode.
- Redirect asserted in the same cycle as a response and a pop: popped instruction completes; response discarded; no request that cycle; next imem_addr=target.
- RESET_PC=32'hFFFF_FFF8: imem_addr sequence FFF8, FFFC, 0000_0000 (wrap); reset_n pulsed low mid-stream returns imem_addr to FFFF_FFF8 and instr_valid to 0 asynchronously.
- FETCH_MISALIGN_CHK_EN defined, redirect to 32'h102: fetch_fault=1 and no requests; a later redirect to 32'h200 clears the fault and resumes fetching at 200. Without the macro, the same 32'h102 redirect fetches from 32'h100.
